// File: rtl/msg_serial_tx.sv
`timescale 1ns/1ps
// Serialises a latched MSG_W-bit message onto one line at the rate set by the
// rising edges of a divider carry-out: start bit, data LSB first, optional even
// parity, then STOP_BITS stop periods. start/busy/done handshake for queuing.
module msg_serial_tx #(
    parameter int unsigned MSG_W     = 5,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic [MSG_W-1:0] msg,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W  = $clog2(MSG_W + 1);
    localparam int unsigned STOP_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                tick_q;
    logic                bit_tick;
    logic [MSG_W-1:0]    shreg_q, shreg_d;
    logic                par_q, par_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [STOP_W-1:0]   stop_cnt_q, stop_cnt_d;
    logic                ser_q, ser_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                last_data;
    logic                last_stop;

    // Rising edge of the divider output; a tick_in already high at reset
    // release is not an edge because tick_q resets to 1.
    assign bit_tick  = tick_in & ~tick_q;

    // The done cycle blocks acceptance so a held start re-arms one cycle later.
    assign accept    = (state_q == S_IDLE) & start & ~done_q;
    assign last_data = (bit_cnt_q == CNT_W'(MSG_W - 1));
    assign last_stop = (stop_cnt_q == STOP_W'(STOP_BITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; everything past IDLE advances only on bit_tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)   state_d = S_SYNC;
            S_SYNC:   if (bit_tick) state_d = S_START;
            S_START:  if (bit_tick) state_d = S_DATA;
            S_DATA: begin
                if (bit_tick && last_data) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_tick) state_d = S_STOP;
            S_STOP:   if (bit_tick && last_stop) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; ser_d carries the bit of the state being entered
    always_comb begin
        shreg_d    = shreg_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ser_d      = ser_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                if (accept) begin
                    shreg_d    = msg;
                    par_d      = ^msg;
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            S_SYNC: begin
                if (bit_tick) ser_d = 1'b0;
            end
            S_START: begin
                if (bit_tick) begin
                    ser_d     = shreg_q[0];
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_data) begin
                        ser_d      = (PARITY_EN != 0) ? par_q : 1'b1;
                        stop_cnt_d = '0;
                    end else begin
                        ser_d = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    ser_d      = 1'b1;
                    stop_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + STOP_W'(1);
                    end
                end
            end
            default: begin
                ser_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath, tick edge-detect and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q     <= 1'b1;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            ser_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q     <= tick_in;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ser_q      <= ser_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_msg_serial_tx.sv
`timescale 1ns/1ps
// Self-checking bench for msg_serial_tx: two instances (parity/1 stop and
// no parity/2 stops) checked cycle by cycle against a frame model built from
// the message bits.
module tb_msg_serial_tx;

    localparam int unsigned MSG_W = 5;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             tick_in = 1'b0;
    logic             start_a = 1'b0;
    logic             start_b = 1'b0;
    logic [MSG_W-1:0] msg_a   = '0;
    logic [MSG_W-1:0] msg_b   = '0;
    logic             ser_a, busy_a, done_a;
    logic             ser_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    int tick_mode = 0;   // 0 = one-clk pulse every tick_per clks, 1 = square wave of period tick_per
    int tick_per  = 4;
    int tick_cnt  = 0;

    logic tick_prev;
    logic edge_now;
    int   sel = 0;       // 0 -> dut_a, 1 -> dut_b
    logic ser_s, busy_s, done_s;

    msg_serial_tx #(.MSG_W(5), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start_a), .msg(msg_a),
        .ser_out(ser_a), .busy(busy_a), .done(done_a)
    );

    msg_serial_tx #(.MSG_W(5), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start_b), .msg(msg_b),
        .ser_out(ser_b), .busy(busy_b), .done(done_b)
    );

    assign ser_s  = (sel == 1) ? ser_b  : ser_a;
    assign busy_s = (sel == 1) ? busy_b : busy_a;
    assign done_s = (sel == 1) ? done_b : done_a;

    always #5 clk = ~clk;

    // Divider stand-in, updated away from the sampling edge
    always @(negedge clk) begin
        if (tick_cnt >= tick_per) tick_cnt = 0;
        if (tick_mode == 0) tick_in = (tick_cnt == 0);
        else                tick_in = (tick_cnt < tick_per / 2);
        tick_cnt = (tick_cnt + 1) % tick_per;
    end

    // Observed bit-rate edges: edge_now marks the clock edge where a bit boundary happened
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_prev <= 1'b1;
            edge_now  <= 1'b0;
        end else begin
            edge_now  <= tick_in & ~tick_prev;
            tick_prev <= tick_in;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_start(input logic v);
        if (sel == 1) start_b = v; else start_a = v;
    endtask

    task automatic set_msg(input logic [MSG_W-1:0] v);
        if (sel == 1) msg_b = v; else msg_a = v;
    endtask

    // Called at #1 after the accepting edge; follows the frame to done and one cycle beyond.
    task automatic run_frame(input logic [MSG_W-1:0] m, input int par_en, input int stops,
                             input bit disturb, input string name);
        logic ex [0:15];
        int   n, k, cyc, ones;
        logic cur;
        n    = 1 + MSG_W + par_en + stops;
        ones = 0;
        ex[0] = 1'b0;
        for (int i = 0; i < MSG_W; i++) begin
            ex[1 + i] = m[i];
            if (m[i]) ones++;
        end
        if (par_en != 0) ex[1 + MSG_W] = ((ones % 2) == 1);
        for (int i = 0; i < stops; i++) ex[1 + MSG_W + par_en + i] = 1'b1;

        n_checks++;
        if (busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy_s);
        end

        cur = 1'b1;
        k   = 0;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 400) begin
                n_checks++; n_fail++;
                $display("FAIL %s timeout: %0d of %0d bit edges seen", name, k, n);
                break;
            end
            if (disturb && cyc == 9) begin
                set_start(1'b1);
                set_msg(~m);
            end
            if (disturb && cyc == 10) begin
                set_start(1'b0);
                set_msg(MSG_W'($urandom));
            end
            if (edge_now) begin
                k++;
                if (k <= n) cur = ex[k - 1];
            end
            if (k > n) begin
                n_checks++;
                if ({ser_s, busy_s, done_s} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL %s frame_end: {ser,busy,done}=%b expected 101", name,
                             {ser_s, busy_s, done_s});
                end
                break;
            end
            n_checks++;
            if ({ser_s, busy_s, done_s} !== {cur, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL %s bit%0d cyc%0d: {ser,busy,done}=%b expected %b", name, k, cyc,
                         {ser_s, busy_s, done_s}, {cur, 1'b1, 1'b0});
            end
        end

        @(posedge clk); #1;
        n_checks++;
        if ({ser_s, busy_s, done_s} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s after_done: {ser,busy,done}=%b expected 100", name,
                     {ser_s, busy_s, done_s});
        end
    endtask

    // Drive a one-cycle start pulse and follow the frame
    task automatic send(input logic [MSG_W-1:0] m, input int par_en, input int stops,
                        input bit disturb, input string name);
        @(negedge clk);
        set_msg(m);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        run_frame(m, par_en, stops, disturb, name);
    endtask

    task automatic test_reset();
        tick_mode = 0;
        tick_per  = 2;
        rst       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ser_a, busy_a, done_a, ser_b, busy_b, done_b} !== 6'b100100) begin
                n_fail++;
                $display("FAIL reset_hold: outputs=%b expected 100100",
                         {ser_a, busy_a, done_a, ser_b, busy_b, done_b});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ser_a, busy_a, done_a, ser_b, busy_b, done_b} !== 6'b100100) begin
                n_fail++;
                $display("FAIL idle_ticks: outputs=%b expected 100100",
                         {ser_a, busy_a, done_a, ser_b, busy_b, done_b});
            end
        end
    endtask

    task automatic test_basic();
        sel       = 0;
        tick_mode = 0;
        tick_per  = 4;
        send(5'b10110, 1, 1, 1'b0, "basic");
    endtask

    task automatic test_square();
        sel       = 0;
        tick_mode = 1;
        tick_per  = 8;
        send(5'b00000, 1, 1, 1'b0, "square_zero");
        for (int i = 0; i < 3; i++) begin
            tick_per = 2 * int'($urandom_range(2, 5));
            send(MSG_W'($urandom), 1, 1, 1'b0, "square_rand");
        end
    endtask

    task automatic test_random();
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            tick_mode = int'($urandom_range(0, 1));
            tick_per  = (tick_mode == 0) ? int'($urandom_range(3, 7))
                                         : 2 * int'($urandom_range(2, 4));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(MSG_W'($urandom), 1, 1, 1'b0, "random");
        end
    endtask

    task automatic test_handshake();
        logic [MSG_W-1:0] m1, m2;
        sel       = 0;
        tick_mode = 0;
        tick_per  = 4;
        send(MSG_W'($urandom), 1, 1, 1'b1, "start_during_busy");

        m1 = MSG_W'($urandom);
        m2 = ~m1;
        @(negedge clk);
        msg_a   = m1;
        start_a = 1'b1;
        @(posedge clk); #1;
        msg_a = MSG_W'($urandom);
        run_frame(m1, 1, 1, 1'b0, "held_first");
        msg_a = m2;
        @(posedge clk); #1;
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reaccept: busy=%b expected 1", busy_a);
        end
        start_a = 1'b0;
        msg_a   = m1;
        run_frame(m2, 1, 1, 1'b0, "held_second");
    endtask

    task automatic test_no_parity();
        sel       = 1;
        tick_mode = 0;
        tick_per  = 4;
        send(5'b11111, 0, 2, 1'b0, "nopar_ones");
        for (int i = 0; i < 4; i++) begin
            tick_mode = int'($urandom_range(0, 1));
            tick_per  = (tick_mode == 0) ? int'($urandom_range(3, 6)) : 8;
            send(MSG_W'($urandom), 0, 2, (i == 2), "nopar_rand");
        end
        sel = 0;
    endtask

    task automatic test_reset_midframe();
        logic [MSG_W-1:0] m;
        int edges, cyc;
        sel       = 0;
        tick_mode = 0;
        tick_per  = 4;
        m         = MSG_W'($urandom);
        @(negedge clk);
        msg_a   = m;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        edges = 0;
        cyc   = 0;
        while (edges < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (edge_now) edges++;
        end
        n_checks++;
        if (edges != 4 || ser_a !== m[2]) begin
            n_fail++;
            $display("FAIL midframe_reach_bit2: edges=%0d ser=%b expected 4 edges ser=%b",
                     edges, ser_a, m[2]);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ser_a, busy_a, done_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_abort: {ser,busy,done}=%b expected 100", {ser_a, busy_a, done_a});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ser_a, busy_a, done_a} !== 3'b100) begin
                n_fail++;
                $display("FAIL abort_hold: {ser,busy,done}=%b expected 100", {ser_a, busy_a, done_a});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ser_a, busy_a, done_a} !== 3'b100) begin
                n_fail++;
                $display("FAIL no_done_after_abort: {ser,busy,done}=%b expected 100",
                         {ser_a, busy_a, done_a});
            end
        end
        send(MSG_W'($urandom), 1, 1, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_square();
        test_random();
        test_handshake();
        test_no_parity();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
